// File: rtl/bp_pkg.sv
// Shared branch-prediction types and constants for the branch resolve queue
// and the direction predictor it trains.
package bp_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned IDX_LO      = 2;
  localparam int unsigned IDX_HI      = 11;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } brq_entry_t;

  typedef enum logic [0:0] {RUN, FLUSH} brq_state_e;

  function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(INSTR_BYTES);
  endfunction

  // Predictor table index for a given PC.
  function automatic logic [IDX_HI-IDX_LO:0] pred_index(input logic [PC_W-1:0] pc);
    return pc[IDX_HI:IDX_LO];
  endfunction

endpackage

// File: rtl/brq_fifo_mem.sv
// Entry storage for the branch resolve queue: one synchronous write port and
// one asynchronous read port.
module brq_fifo_mem
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  brq_entry_t       i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output brq_entry_t       o_rdata
);

  brq_entry_t r_mem [DEPTH];

  // No reset: validity is tracked by the pointers and count in the parent.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves them, trains the predictor and
// raises mispredict redirects. Optional stats counters: BRQ_MISPREDICT_STATS_EN.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FetchValid,
  input  logic [PC_W-1:0] FetchPC,
  input  logic            FetchPredTaken,
  input  logic [PC_W-1:0] FetchPredTarget,
  output logic            Full,
  input  logic            ResolveValid,
  input  logic            ResolveTaken,
  input  logic [PC_W-1:0] ResolveTarget,
  output logic            UpdateValid,
  output logic            UpdateTaken,
  output logic [PC_W-1:0] UpdatePC,
  output logic            Mispredict,
  output logic [PC_W-1:0] RedirectPC,
  output logic [PTR_W:0]  Count,
  output logic            ErrUnderflow,
  output logic [31:0]     StatBranches,
  output logic [31:0]     StatMispredicts
);

  brq_state_e r_state, w_state_next;
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;

  logic            r_upd_valid, r_upd_taken, r_mispredict, r_err_underflow;
  logic [PC_W-1:0] r_upd_pc, r_redirect_pc;

  logic       w_empty, w_full, w_run, w_push, w_pop, w_mis, w_mis_pop, w_wr;
  brq_entry_t w_wr_entry, w_head_entry;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_run   = (r_state == RUN);

  // Full depends only on the registered count, so a same-cycle pop never frees a slot.
  assign w_push = w_run & FetchValid & ~w_full;
  assign w_pop  = w_run & ResolveValid & ~w_empty;

  assign w_mis = (w_head_entry.pred_taken != ResolveTaken) ||
                 (w_head_entry.pred_taken && ResolveTaken &&
                  (w_head_entry.pred_target != ResolveTarget));
  assign w_mis_pop = w_pop & w_mis;
  assign w_wr      = w_push & ~w_mis_pop;

  assign w_wr_entry = '{pc: FetchPC, pred_taken: FetchPredTaken, pred_target: FetchPredTarget};

  brq_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_wr),
    .i_waddr (r_tail),
    .i_wdata (w_wr_entry),
    .i_raddr (r_head),
    .o_rdata (w_head_entry)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RUN:     if (w_mis_pop) w_state_next = FLUSH;
      FLUSH:   w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= RUN;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_mis_pop) begin
        // Drop every younger entry along with any same-cycle push.
        r_head  <= r_head + PTR_W'(1);
        r_tail  <= r_head + PTR_W'(1);
        r_count <= '0;
      end else begin
        if (w_pop) r_head <= r_head + PTR_W'(1);
        if (w_wr)  r_tail <= r_tail + PTR_W'(1);
        if (w_wr && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
        else if (w_pop && !w_wr) r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_upd_valid     <= 1'b0;
      r_upd_taken     <= 1'b0;
      r_upd_pc        <= '0;
      r_mispredict    <= 1'b0;
      r_redirect_pc   <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_upd_valid  <= w_pop;
      r_mispredict <= w_mis_pop;
      if (w_pop) begin
        r_upd_taken <= ResolveTaken;
        r_upd_pc    <= w_head_entry.pc;
      end
      if (w_mis_pop) begin
        r_redirect_pc <= ResolveTaken ? ResolveTarget : next_seq_pc(w_head_entry.pc);
      end
      if (w_run && ResolveValid && w_empty) r_err_underflow <= 1'b1;
    end
  end

`ifdef BRQ_MISPREDICT_STATS_EN
  logic [31:0] r_stat_branches, r_stat_mispredicts;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_pop)     r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_mis_pop) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign StatBranches    = r_stat_branches;
  assign StatMispredicts = r_stat_mispredicts;
`else
  assign StatBranches    = '0;
  assign StatMispredicts = '0;
`endif

  assign Full         = w_full;
  assign Count        = r_count;
  assign UpdateValid  = r_upd_valid;
  assign UpdateTaken  = r_upd_taken;
  assign UpdatePC     = r_upd_pc;
  assign Mispredict   = r_mispredict;
  assign RedirectPC   = r_redirect_pc;
  assign ErrUnderflow = r_err_underflow;

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks every predicted branch from fetch until it resolves in execute.
- Compares the predicted direction and target against the resolved outcome, and raises a mispredict with a redirect PC.
- Drives the per-branch training strobe into the downstream 1024-entry 2-bit direction predictor: UpdateValid feeds isBranch, UpdateTaken feeds isTaken, UpdatePC feeds InstrPC.
- In-order FIFO; branches resolve in program order.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width, derived.

Ports:
- CLK  input  1  single clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- FetchValid  input  1  branch fetched this cycle; push request.
- FetchPC  input  32  PC of the fetched branch.
- FetchPredTaken  input  1  direction predicted at fetch (Pred[FetchPC[11:2]]).
- FetchPredTarget  input  32  target used at fetch if predicted taken.
- Full  output  1  queue full; push is ignored while high.
- ResolveValid  input  1  oldest branch resolved this cycle.
- ResolveTaken  input  1  actual direction.
- ResolveTarget  input  32  actual taken target.
- UpdateValid  output  1  one-cycle training pulse to the predictor.
- UpdateTaken  output  1  resolved direction for training.
- UpdatePC  output  32  PC of the resolved branch.
- Mispredict  output  1  one-cycle pulse; fetch must redirect.
- RedirectPC  output  32  correct next PC, valid while Mispredict=1.
- Count  output  PTR_W+1  number of entries held.
- ErrUnderflow  output  1  sticky; set by ResolveValid while empty.
- StatBranches, StatMispredicts  output  32 each  present only with the optional feature; see below.

Behaviour:
- Reset (async, RESET=1): pointers=0, Count=0, Full=0, state=RUN. All outputs 0: UpdateValid, UpdateTaken, UpdatePC, Mispredict, RedirectPC, ErrUnderflow, and the stat counters. RESET asserted mid-operation discards all entries immediately.
- Storage per entry: {PC[31:0], PredTaken, PredTarget[31:0]}. Circular buffer with head and tail pointers that wrap at DEPTH. Count is tracked separately, so Full = (Count==DEPTH) and Empty = (Count==0).
- State machine, 2 states:
  - RUN: normal push and pop.
  - FLUSH: entered in the cycle after a mispredict; lasts exactly 1 cycle. FetchValid is ignored (wrong-path bubble). ResolveValid is ignored, and UpdateValid stays 0. Then returns to RUN.
- Push (RUN only): when FetchValid && !Full, write the entry at tail, tail+1.
- Pop (RUN only): when ResolveValid && !Empty, read the head entry and set head+1.
  - Mispredict condition: (PredTaken != ResolveTaken) || (PredTaken && ResolveTaken && PredTarget != ResolveTarget).
- Outputs are registered with 1-cycle latency after a pop:
  - UpdateValid=1, UpdateTaken=ResolveTaken, UpdatePC=entry PC.
  - On the mispredict condition: Mispredict=1 and RedirectPC = ResolveTaken ? ResolveTarget : PC+4 (32-bit wrap).
  - UpdateValid and Mispredict are each high for exactly 1 cycle per pop.
- Mispredict flush, in the same edge as the pop:
  - Every younger entry is discarded: tail=head+1 and Count=0.
  - A push in the same cycle is dropped.
  - Next state is FLUSH.
- Simultaneous push and pop with no mispredict: both are performed and Count is unchanged. When Full, the push is still refused even though a pop occurs that cycle, so Full depends only on registered Count.
- Underflow: ResolveValid while Empty in RUN sets ErrUnderflow=1 (sticky until RESET); no pop and no update pulse.
- Full while FetchValid: the push is dropped and there is no error flag. The fetch stage must stall on Full.

Optional Feature:
- Macro: BRQ_MISPREDICT_STATS_EN.
- Defined: StatBranches increments on every pop, and StatMispredicts on every mispredict. Both are 32-bit, wrap at 2^32, reset to 0, and update with the same 1-cycle latency as UpdateValid.
- Undefined: the ports still exist but are tied to 0, and no counters are synthesized.

Decomposition:
- Shared package bp_pkg holds:
  - PC_W=32, INSTR_BYTES=4.
  - Predictor index slice constants IDX_LO=2, IDX_HI=11.
  - Typedef brq_entry_t {pc, pred_taken, pred_target}.
  - State enum {RUN, FLUSH}.
- One sub-module, brq_fifo_mem: DEPTH x brq_entry_t storage with a write port and an async read port. Pointers, FSM and compare logic stay in the top module.

Test Plan:
- Push PC=0x100 (PredTaken=1, tgt 0x200), then resolve Taken with tgt 0x200 → next cycle UpdateValid=1, UpdatePC=0x100, UpdateTaken=1, Mispredict=0, Count=0.
- Push PC=0x104 (PredTaken=1), resolve NotTaken → Mispredict=1, RedirectPC=0x108, UpdateTaken=0. The following cycle is FLUSH: FetchValid push ignored, Count stays 0.
- Push 3 branches, then resolve the first with a target mismatch (pred 0x300, actual 0x340) → RedirectPC=0x340, Count=0, the 2 younger entries are never updated.
- Push 8 entries → Full=1; the 9th push is dropped. Simultaneous push and pop with Full=1 → Count=7, only the pop is performed. Continue until the pointers wrap, and confirm FIFO order over 20 entries.
- ResolveValid with the queue empty → ErrUnderflow=1 and stays set, UpdateValid=0. Assert RESET with 4 entries held → immediately Count=0, ErrUnderflow=0, all outputs 0.
- With BRQ_MISPREDICT_STATS_EN defined, 10 pops with 3 mispredicts → StatBranches=10, StatMispredicts=3. Without the macro → both read 0.
